// File: rtl/word_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : word_framer_pkg
//  Purpose  : Shared character constants, case-fold offset and framer state
//             encoding for the word_framer block.
//  Revision : 1.0 - initial release
// ============================================================================
package word_framer_pkg;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_NUL   = 8'h00;

    // Distance from an uppercase ASCII letter to its lowercase form
    localparam logic [7:0] CASE_FOLD_OFFSET = 8'h20;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EMIT    = 2'd1,
        SEP     = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/word_framer_char_classify.sv
`default_nettype none
// ============================================================================
//  Module   : word_framer_char_classify
//  Purpose  : Combinational byte classifier (char_classify): folds A-Z to
//             lowercase, flags whitespace delimiters and NUL bytes to drop.
//  Revision : 1.0 - initial release
// ============================================================================
module word_framer_char_classify
    import word_framer_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_folded,
    output logic       o_is_delim,
    output logic       o_is_drop
);

    // Classify and case-fold the incoming byte
    always_comb begin
        o_folded   = i_byte;
        o_is_delim = 1'b0;
        o_is_drop  = 1'b0;
        if ((i_byte >= 8'h41) && (i_byte <= 8'h5A)) begin
            o_folded = i_byte + CASE_FOLD_OFFSET;
        end
        if ((i_byte == CH_SPACE) || (i_byte == CH_TAB) ||
            (i_byte == CH_LF)    || (i_byte == CH_CR)) begin
            o_is_delim = 1'b1;
        end
        if (i_byte == CH_NUL) begin
            o_is_drop = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/word_framer.sv
`default_nettype none
// ============================================================================
//  Module   : word_framer
//  Purpose  : Buffers a stallable byte stream into whole lowercase words and
//             bursts each word out contiguously, followed by one space.
//             Optional committed-word counter enabled by macro
//             WORD_FRAMER_STATS_EN (word_cnt tied to zero otherwise).
//  Revision : 1.0 - initial release
// ============================================================================
module word_framer
    import word_framer_pkg::*;
#(
    parameter int         MAX_WORD  = 16,
    parameter logic [7:0] FILL_CHAR = 8'h20
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [7:0]  out_char,
    output logic        out_valid,
    output logic [15:0] word_cnt
);

    // Length counters must hold MAX_WORD itself; buffer addresses only reach MAX_WORD-1
    localparam int              c_LW      = $clog2(MAX_WORD + 1);
    localparam int              c_AW      = $clog2(MAX_WORD);
    localparam logic [c_LW-1:0] c_MAX_LEN = c_LW'(MAX_WORD);
    localparam logic [c_LW-1:0] c_ONE     = c_LW'(1);

    state_t          r_state;
    logic [7:0]      r_buf [MAX_WORD];
    logic [c_LW-1:0] r_len;
    logic [c_LW-1:0] r_idx;
    logic [7:0]      r_out_char;
    logic            r_out_valid;

    logic [7:0]      w_folded;
    logic            w_is_delim;
    logic            w_is_drop;
    logic            w_xfer;
    logic            w_store;
    logic [c_LW-1:0] w_len_next;
    logic            w_commit;

    word_framer_char_classify u_classify (
        .i_byte     (in_data),
        .o_folded   (w_folded),
        .o_is_delim (w_is_delim),
        .o_is_drop  (w_is_drop)
    );

    assign in_ready   = (r_state == COLLECT);
    assign w_xfer     = in_valid && in_ready;
    // Bytes past MAX_WORD are accepted but not stored, so long words get truncated
    assign w_store    = w_xfer && !w_is_delim && !w_is_drop && (r_len < c_MAX_LEN);
    assign w_len_next = w_store ? (r_len + c_ONE) : r_len;
    // A byte arriving with flush joins the word before the commit decision
    assign w_commit   = (w_xfer && w_is_delim && (r_len != '0)) ||
                        (flush && (w_len_next != '0));

    // Collect / emit / separator sequencer with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= COLLECT;
            r_len       <= '0;
            r_idx       <= '0;
            r_out_char  <= FILL_CHAR;
            r_out_valid <= 1'b0;
            for (int i = 0; i < MAX_WORD; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                COLLECT: begin
                    r_out_char  <= FILL_CHAR;
                    r_out_valid <= 1'b0;
                    if (w_store) begin
                        r_buf[r_len[c_AW-1:0]] <= w_folded;
                    end
                    r_len <= w_len_next;
                    if (w_commit) begin
                        r_idx   <= '0;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    r_out_char  <= r_buf[r_idx[c_AW-1:0]];
                    r_out_valid <= 1'b1;
                    r_idx       <= r_idx + c_ONE;
                    if (r_idx == (r_len - c_ONE)) begin
                        r_state <= SEP;
                    end
                end
                SEP: begin
                    r_out_char  <= CH_SPACE;
                    r_out_valid <= 1'b1;
                    r_len       <= '0;
                    r_state     <= COLLECT;
                end
                default: begin
                    r_out_char  <= FILL_CHAR;
                    r_out_valid <= 1'b0;
                    r_state     <= COLLECT;
                end
            endcase
        end
    end

    assign out_char  = r_out_char;
    assign out_valid = r_out_valid;

`ifdef WORD_FRAMER_STATS_EN
    logic [15:0] r_word_cnt;

    // Count words as their separator goes out, saturating at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_cnt <= '0;
        end else if ((r_state == SEP) && (r_word_cnt != 16'hFFFF)) begin
            r_word_cnt <= r_word_cnt + 16'd1;
        end
    end

    assign word_cnt = r_word_cnt;
`else
    assign word_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_word_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_word_framer
//  Purpose  : Directed self-checking bench for word_framer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_word_framer;

    localparam int MAX_WORD = 16;
`ifdef WORD_FRAMER_STATS_EN
    localparam int c_STATS = 1;
`else
    localparam int c_STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [7:0]  out_char;
    logic        out_valid;
    logic [15:0] word_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  q[$];
    int          qc[$];
    int          cyc = 0;
    int          stall_cnt = 0;
    int          fill_bad = 0;

    word_framer #(
        .MAX_WORD  (MAX_WORD),
        .FILL_CHAR (8'h20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_char  (out_char),
        .out_valid (out_valid),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    // Cycle counter used to verify contiguous emission
    always @(posedge clk) cyc++;

    // Capture emitted characters, stall cycles and idle-fill violations
    always @(negedge clk) begin
        if (out_valid) begin
            q.push_back(out_char);
            qc.push_back(cyc);
        end else if (out_char !== 8'h20) begin
            fill_bad++;
        end
        if (!in_ready) stall_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int wc(input int n);
        return (c_STATS != 0) ? n : 0;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fl);
        int guard;
        in_data  = b;
        in_valid = 1'b1;
        flush    = fl;
        guard    = 0;
        while (!in_ready && guard < 64) begin
            step();
            guard++;
        end
        if (guard >= 64) check("send_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
    endtask

    task automatic check_seq(input string tag, input string exp);
        check({tag, "_len"}, q.size(), exp.len());
        for (int i = 0; i < exp.len() && i < q.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), {24'd0, q[i]}, {24'd0, exp[i]});
        end
        q.delete();
        qc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        string xs;

        // Reset state
        step();
        check("rst_out_char", out_char, 8'h20);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_word_cnt", word_cnt, 16'd0);
        reset = 1'b0;
        step();

        // Two words with in_valid held high
        stall_cnt = 0;
        send_str("BeGiN ");
        send_byte("e", 1'b0);
        check("t1_stall_w1", stall_cnt, 6);
        stall_cnt = 0;
        send_str("nd ");
        idle(20);
        check("t1_stall_w2", stall_cnt, 4);
        if (q.size() == 10) begin
            check("t1_contig_w1", qc[5] - qc[0], 5);
            check("t1_contig_w2", qc[9] - qc[6], 3);
        end
        check_seq("t1", "begin end ");
        check("t1_word_cnt", word_cnt, wc(2));

        // Leading whitespace squeezed, word committed by flush
        do_reset();
        stall_cnt = 0;
        send_str("  \t\r\nend");
        check("t2_no_stall", stall_cnt, 0);
        check("t2_no_out", q.size(), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle(20);
        check_seq("t2", "end ");
        check("t2_word_cnt", word_cnt, wc(1));

        // Flush in the same cycle as a letter: letter joins the word
        send_str("o");
        send_byte("k", 1'b1);
        idle(20);
        check_seq("t2b", "ok ");
        check("t2b_word_cnt", word_cnt, wc(2));

        // Input gap inside a word does not split its emission
        send_str("be");
        idle(5);
        send_str("gin ");
        idle(20);
        if (q.size() == 6) check("t3_contig", qc[5] - qc[0], 5);
        check_seq("t3", "begin ");

        // Truncation at MAX_WORD: excess bytes accepted and dropped
        stall_cnt = 0;
        for (int i = 0; i < 20; i++) send_byte("x", 1'b0);
        check("t4_no_stall", stall_cnt, 0);
        send_byte(" ", 1'b0);
        idle(30);
        xs = "";
        for (int i = 0; i < MAX_WORD; i++) xs = {xs, "x"};
        xs = {xs, " "};
        check_seq("t4", xs);

        // Reset two cycles into EMIT abandons the word
        send_str("begin ");
        step();
        step();
        reset = 1'b1;
        #1;
        check("t5_rst_out_char", out_char, 8'h20);
        check("t5_rst_out_valid", out_valid, 1'b0);
        check("t5_rst_word_cnt", word_cnt, 16'd0);
        step();
        reset = 1'b0;
        #1;
        check("t5_in_ready", in_ready, 1'b1);
        check_seq("t5_partial", "be");
        send_str("end ");
        idle(20);
        check_seq("t5", "end ");

        // NUL is dropped and does not delimit
        send_str("a");
        send_byte(8'h00, 1'b0);
        send_str("b ");
        idle(20);
        check_seq("t6", "ab ");
        check("t6_word_cnt", word_cnt, wc(2));

        check("fill_when_idle", fill_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
